instr_encoder_writer: RTL and testbench

//  Encoder side of the control-unit instruction format. Takes field-level requests (data

---
 rtl/instr_encoder_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_instr_encoder_writer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_writer.sv
// ----------------------------------------------------------------------------
// instr_encoder_writer
//
// Builds 32-bit control-unit instruction words from field-level requests
// (data-processing, load/store, branch) and writes them one after another
// into instruction memory. The boot loader uses it to fill program memory
// before the pipeline starts.
//
// Each request passes through three states: IDLE (handshake), ENCODE
// (legality check and word build) and WRITE (a one-cycle mem_we pulse).
// An illegal request completes the handshake, writes nothing and sets the
// sticky err flag.
//
// Ports
//   clk          clock, single domain
//   reset        synchronous, active-high reset
//   clear        synchronous restart: count, full and err return to 0 and
//                any pending operation is dropped
//   req_valid    request present
//   req_ready    encoder can accept: IDLE, not full, no clear this cycle
//   req_kind     00 data-proc, 01 load/store, 10 branch, 11 illegal
//   req_cond     condition field [31:28]
//   req_alu_op   internal ALU opcode (data-proc only)
//   req_s        S bit (data-proc only)
//   req_rn       base / first-operand register
//   req_rd       destination / source register
//   req_imm12    immediate operand / offset
//   req_load     1 load, 0 store
//   req_byte     1 byte, 0 word
//   req_link     1 branch-and-link, 0 plain branch
//   req_imm24    branch offset
//   mem_we       one-cycle write strobe
//   mem_addr     BASE_ADDR + 4*word_count, truncated to ADDR_W
//   mem_wdata    encoded instruction; holds its value while mem_we=0
//   word_count   words written since reset/clear; never wraps
//   full         word_count == DEPTH
//   err          sticky illegal-request flag
// ----------------------------------------------------------------------------
module instr_encoder_writer #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_alu_op,
    input  logic              req_s,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [11:0]       req_imm12,
    input  logic              req_load,
    input  logic              req_byte,
    input  logic              req_link,
    input  logic [23:0]       req_imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  word_count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        WRITE
    } state_t;

    typedef enum logic [1:0] {
        KIND_DP  = 2'b00,
        KIND_LS  = 2'b01,
        KIND_BR  = 2'b10,
        KIND_BAD = 2'b11
    } kind_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t state;

    // Request fields captured on accept
    kind_t       kind_q;
    logic [3:0]  cond_q;
    logic [3:0]  alu_op_q;
    logic        s_q;
    logic [3:0]  rn_q;
    logic [3:0]  rd_q;
    logic [11:0] imm12_q;
    logic        load_q;
    logic        byte_q;
    logic        link_q;
    logic [23:0] imm24_q;

    logic        accept;
    logic [3:0]  arm_op;
    logic        arm_op_ok;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign full      = (word_count == CNT_W'(DEPTH));
    assign req_ready = (state == IDLE) && !full && !clear;
    assign accept    = req_valid && req_ready;

    // Internal ALU opcode to the decode's 4-bit data-processing opcode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        arm_op    = 4'b0000;
        arm_op_ok = 1'b1;
        unique case (alu_op_q)
            4'b0110: arm_op = 4'b0000; // AND
            4'b1000: arm_op = 4'b0001; // EOR
            4'b0010: arm_op = 4'b0010; // SUB
            4'b0100: arm_op = 4'b0011; // RSB
            4'b0000: arm_op = 4'b0100; // ADD
            4'b0001: arm_op = 4'b0101; // ADC
            4'b0011: arm_op = 4'b0110; // SBC
            4'b0101: arm_op = 4'b0111; // RSC
            4'b0111: arm_op = 4'b1100; // ORR
            4'b1010: arm_op = 4'b1101; // MOV
            4'b1100: arm_op = 4'b1110; // BIC
            4'b1011: arm_op = 4'b1111; // MVN
            default: arm_op_ok = 1'b0;
        endcase
    end

    // Instruction word from the captured fields.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        unique case (kind_q)
            KIND_DP: begin
                enc_legal = arm_op_ok;
                enc_word  = {cond_q, 3'b001, arm_op, s_q, rn_q, rd_q, imm12_q};
            end
            KIND_LS: begin
                // Pre-indexed, offset added, no write-back; bit 22 set means word.
                enc_legal = 1'b1;
                enc_word  = {cond_q, 3'b010, 1'b1, 1'b1, ~byte_q, 1'b0, load_q,
                             rn_q, rd_q, imm12_q};
            end
            KIND_BR: begin
                // Decode treats bit 24 set as plain B, clear as BL.
                enc_legal = 1'b1;
                enc_word  = {cond_q, 3'b101, ~link_q, imm24_q};
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    // NOTE: the field capture registers carry no reset; they are only read in
    // ENCODE, which is always reached through an accept that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            kind_q   <= kind_t'(req_kind);
            cond_q   <= req_cond;
            alu_op_q <= req_alu_op;
            s_q      <= req_s;
            rn_q     <= req_rn;
            rd_q     <= req_rd;
            imm12_q  <= req_imm12;
            load_q   <= req_load;
            byte_q   <= req_byte;
            link_q   <= req_link;
            imm24_q  <= req_imm24;
        end
    end

    // Control FSM with registered outputs. Reset and clear both drop any
    // operation in flight, so a pending write never reaches mem_we.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= 32'h0;
            word_count <= '0;
            err        <= 1'b0;
        end else if (clear) begin
            // mem_addr/mem_wdata keep their last values; only the strobe drops.
            state      <= IDLE;
            mem_we     <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (accept) begin
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (enc_legal) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + ADDR_W'({word_count, 2'b00});
                        mem_wdata <= enc_word;
                        state     <= WRITE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    word_count <= word_count + CNT_W'(1);
                    state      <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder_writer
//
// Drives directed and random requests into instr_encoder_writer (DEPTH=4 so
// the full condition is reached often). A cycle-level reference model
// predicts req_ready, word_count, full and err; every accepted legal request
// pushes its expected write (cycle, address, word) into a scoreboard queue
// that an independent monitor drains whenever mem_we is seen.
// ----------------------------------------------------------------------------
module tb_instr_encoder_writer;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_kind = '0;
    logic [3:0]        req_cond = '0;
    logic [3:0]        req_alu_op = '0;
    logic              req_s = 1'b0;
    logic [3:0]        req_rn = '0;
    logic [3:0]        req_rd = '0;
    logic [11:0]       req_imm12 = '0;
    logic              req_load = 1'b0;
    logic              req_byte = 1'b0;
    logic              req_link = 1'b0;
    logic [23:0]       req_imm24 = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [CNT_W-1:0]  word_count;
    logic              full;
    logic              err;

    instr_encoder_writer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_cond  (req_cond),
        .req_alu_op(req_alu_op),
        .req_s     (req_s),
        .req_rn    (req_rn),
        .req_rd    (req_rd),
        .req_imm12 (req_imm12),
        .req_load  (req_load),
        .req_byte  (req_byte),
        .req_link  (req_link),
        .req_imm24 (req_imm24),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .word_count(word_count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  alu;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] imm12;
        logic        load;
        logic        byt;
        logic        link;
        logic [23:0] imm24;
    } req_t;

    typedef struct {
        int                c;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_count = 0;
    bit          m_err   = 1'b0;
    int          m_busy  = 0;   // cycles still unavailable after an accept
    bit          in_reset = 1'b1;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;

    // ALU opcode table: bit 4 marks a legal entry, bits 3:0 the decode opcode.
    logic [4:0] alu_tab [16];

    initial begin
        for (int i = 0; i < 16; i++) alu_tab[i] = 5'h00;
        alu_tab[4'b0110] = 5'h10; alu_tab[4'b1000] = 5'h11;
        alu_tab[4'b0010] = 5'h12; alu_tab[4'b0100] = 5'h13;
        alu_tab[4'b0000] = 5'h14; alu_tab[4'b0001] = 5'h15;
        alu_tab[4'b0011] = 5'h16; alu_tab[4'b0101] = 5'h17;
        alu_tab[4'b0111] = 5'h1C; alu_tab[4'b1010] = 5'h1D;
        alu_tab[4'b1100] = 5'h1E; alu_tab[4'b1011] = 5'h1F;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_legal(input req_t r);
        logic [4:0] e;
        e = alu_tab[r.alu];
        case (r.kind)
            2'b00:   return e[4];
            2'b01:   return 1'b1;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input req_t r);
        logic [4:0] e;
        e = alu_tab[r.alu];
        case (r.kind)
            2'b00:   return {r.cond, 3'b001, e[3:0], r.s, r.rn, r.rd, r.imm12};
            2'b01:   return {r.cond, 3'b010, 2'b11, ~r.byt, 1'b0, r.load, r.rn, r.rd, r.imm12};
            2'b10:   return {r.cond, 3'b101, ~r.link, r.imm24};
            default: return 32'h0;
        endcase
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.kind  = 2'($urandom_range(0, 3));
        r.cond  = 4'($urandom);
        r.alu   = 4'($urandom);
        r.s     = 1'($urandom);
        r.rn    = 4'($urandom);
        r.rd    = 4'($urandom);
        r.imm12 = 12'($urandom);
        r.load  = 1'($urandom);
        r.byt   = 1'($urandom);
        r.link  = 1'($urandom);
        r.imm24 = 24'($urandom);
        return r;
    endfunction

    function automatic req_t mk(input logic [1:0] kind, input logic [3:0] cond,
                                input logic [3:0] alu, input logic s,
                                input logic [3:0] rn, input logic [3:0] rd,
                                input logic [11:0] imm12, input logic load,
                                input logic byt, input logic link,
                                input logic [23:0] imm24);
        req_t r;
        r.kind = kind; r.cond = cond; r.alu = alu; r.s = s; r.rn = rn;
        r.rd = rd; r.imm12 = imm12; r.load = load; r.byt = byt;
        r.link = link; r.imm24 = imm24;
        return r;
    endfunction

    function automatic bit model_ready();
        return (m_busy == 0) && (m_count < DEPTH);
    endfunction

    // Drop expected writes that a reset/clear at the current cycle cancels.
    task automatic prune_future();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c > cyc) sb.delete(i);
        end
    endtask

    // One clock cycle of stimulus plus the model's per-cycle checks.
    task automatic step(input bit v, input bit clr, input req_t r,
                        input bit use_lit = 1'b0, input logic [31:0] lit = 32'h0);
        bit   ready_exp;
        exp_t e;
        @(negedge clk);
        req_valid  = v;
        clear      = clr;
        req_kind   = r.kind;  req_cond  = r.cond;  req_alu_op = r.alu;
        req_s      = r.s;     req_rn    = r.rn;    req_rd     = r.rd;
        req_imm12  = r.imm12; req_load  = r.load;  req_byte   = r.byt;
        req_link   = r.link;  req_imm24 = r.imm24;
        ready_exp  = model_ready() && !clr;
        #1;
        check("req_ready", req_ready, ready_exp);
        if (m_busy == 0) begin
            check("word_count", word_count, m_count);
            check("full", full, (m_count == DEPTH));
            check("err", err, m_err);
        end
        if (clr) begin
            prune_future();
            m_count = 0;
            m_err   = 1'b0;
            m_busy  = 0;
        end else if (v && ready_exp) begin
            if (model_legal(r)) begin
                e.c    = cyc + 2;
                e.addr = ADDR_W'(BASE_ADDR + 4 * m_count);
                e.data = use_lit ? lit : model_word(r);
                sb.push_back(e);
                m_count++;
                m_busy = 2;
            end else begin
                m_err  = 1'b1;
                m_busy = 1;
            end
        end else if (m_busy > 0) begin
            m_busy--;
        end
    endtask

    task automatic idle(input int n);
        req_t z;
        z = mk(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0, 1'b0, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, z);
    endtask

    // Wait (bounded) until the model says the DUT is ready, then issue r.
    task automatic send(input req_t r, input bit use_lit = 1'b0,
                        input logic [31:0] lit = 32'h0);
        int waited;
        waited = 0;
        while (!model_ready() && waited < 10) begin
            idle(1);
            waited++;
        end
        if (!model_ready()) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: encoder not ready after %0d cycles", waited);
        end else begin
            step(1'b1, 1'b0, r, use_lit, lit);
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        clear     = 1'b0;
        prune_future();
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, ADDR_W'(BASE_ADDR));
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_word_count", word_count, 0);
        check("rst_full", full, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        m_count   = 0;
        m_err     = 1'b0;
        m_busy    = 0;
        last_addr = ADDR_W'(BASE_ADDR);
        last_data = 32'h0;
        reset     = 1'b0;
        in_reset  = 1'b0;
    endtask

    // Monitor: every mem_we must match the oldest expected write in both
    // cycle and content; outputs must hold while mem_we is low.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c < cyc) begin
            tests++;
            fails++;
            $display("FAIL write_missing: expected mem_we at cycle %0d, still absent at cycle %0d",
                     sb[0].c, cyc);
            void'(sb.pop_front());
        end
        if (mem_we) begin
            if (sb.size() > 0 && sb[0].c == cyc) begin
                check("mem_addr", mem_addr, sb[0].addr);
                check("mem_wdata", mem_wdata, sb[0].data);
                last_addr = mem_addr;
                last_data = mem_wdata;
                void'(sb.pop_front());
            end else begin
                tests++;
                fails++;
                $display("FAIL write_unexpected: mem_we at cycle %0d addr %0h data %0h, none expected",
                         cyc, mem_addr, mem_wdata);
            end
        end else if (!in_reset) begin
            check("hold_mem_addr", mem_addr, last_addr);
            check("hold_mem_wdata", mem_wdata, last_data);
        end
    end

    initial begin
        req_t r;
        bit   v;
        bit   c;

        // T1: reset
        do_reset();
        idle(2);

        // T2: data-processing ADD
        send(mk(2'b00, 4'hE, 4'b0000, 1'b1, 4'd1, 4'd2, 12'h005, 1'b0, 1'b0, 1'b0, 24'h0),
             1'b1, 32'hE291_2005);
        idle(3);

        // T3: load byte then load word
        send(mk(2'b01, 4'hE, 4'h0, 1'b0, 4'd3, 4'd4, 12'h010, 1'b1, 1'b1, 1'b0, 24'h0),
             1'b1, 32'hE593_4010);
        send(mk(2'b01, 4'hE, 4'h0, 1'b0, 4'd3, 4'd4, 12'h010, 1'b1, 1'b0, 1'b0, 24'h0),
             1'b1, 32'hE5D3_4010);
        idle(3);
        step(1'b0, 1'b1, rand_req());
        idle(1);

        // T4: branch-and-link then plain branch
        send(mk(2'b10, 4'hE, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0, 1'b0, 1'b0, 1'b1, 24'h000010),
             1'b1, 32'hEA00_0010);
        send(mk(2'b10, 4'hE, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0, 1'b0, 1'b0, 1'b0, 24'h000010),
             1'b1, 32'hEB00_0010);
        idle(3);

        // T5: unmapped ALU op, then kind 11
        send(mk(2'b00, 4'hE, 4'b1001, 1'b0, 4'd1, 4'd2, 12'h0, 1'b0, 1'b0, 1'b0, 24'h0));
        send(mk(2'b11, 4'hE, 4'b0000, 1'b0, 4'd1, 4'd2, 12'h0, 1'b0, 1'b0, 1'b0, 24'h0));
        idle(3);

        // T6: fill to DEPTH, stall while full, then clear
        step(1'b0, 1'b1, rand_req());
        idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            r = rand_req();
            r.kind = 2'b10;
            send(r);
        end
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rand_req());
        step(1'b1, 1'b1, rand_req());
        idle(2);

        // Random traffic with occasional clears and one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            v = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 29) == 0);
            step(v, c, rand_req());
        end
        idle(6);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound in case a wait never returns.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
